// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared Hack word and RAM8 geometry definitions
package hack_pkg;
   localparam int WORD_W      = 16;
   localparam int RAM8_DEPTH  = 8;
   localparam int RAM8_ADDR_W = 3;

   typedef logic [WORD_W-1:0] hack_word_t;
endpackage

// File: rtl/hack_ram8_if.sv
// rtl/hack_ram8_if.sv - write/read port bundle for hack_ram8
interface hack_ram8_if
   import hack_pkg::*;
#(
   parameter int WIDTH  = WORD_W,
   parameter int ADDR_W = RAM8_ADDR_W
);
   logic              load;
   logic [ADDR_W-1:0] addr_wr;
   logic [WIDTH-1:0]  d_in;
   logic              rd_en;
   logic [ADDR_W-1:0] addr_rd;
   logic [WIDTH-1:0]  d_out;
   logic              rd_valid;

   modport master (
      output load, addr_wr, d_in, rd_en, addr_rd,
      input  d_out, rd_valid
   );

   modport slave (
      input  load, addr_wr, d_in, rd_en, addr_rd,
      output d_out, rd_valid
   );
endinterface

// File: rtl/hack_register.sv
// rtl/hack_register.sv - WIDTH-bit load register with async active-low clear
module hack_register
   import hack_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
);
   logic [WIDTH-1:0] r_q;

   // An X on load takes the else path in simulation, so the word is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= d_in;
      end
   end

   assign d_out = r_q;
endmodule

// File: rtl/hack_ram8.sv
// rtl/hack_ram8.sv - 8x16 Hack RAM8 with registered read port and write-first bypass
module hack_ram8
   import hack_pkg::*;
#(
   parameter int WIDTH  = WORD_W,
   parameter int DEPTH  = RAM8_DEPTH,
   parameter int ADDR_W = RAM8_ADDR_W
) (
   input logic       clk,
   input logic       rst_n,
   hack_ram8_if.slave bus
);
   logic [DEPTH-1:0] w_we;
   logic [WIDTH-1:0] w_word [DEPTH];
   logic [WIDTH-1:0] w_rd_data;
   logic             w_hit;
   logic             w_valid_nxt;
   logic [WIDTH-1:0] r_d_out;
   logic             r_rd_valid;

   always_comb begin
      w_we = '0;
      if (bus.load) begin
         w_we[bus.addr_wr] = 1'b1;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      hack_register #(.WIDTH(WIDTH)) u_word (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (w_we[gi]),
         .d_in  (bus.d_in),
         .d_out (w_word[gi])
      );
   end

   // Same-address write and read on one edge returns the incoming data.
   always_comb begin
      w_hit     = bus.load && (bus.addr_wr == bus.addr_rd);
      w_rd_data = w_hit ? bus.d_in : w_word[bus.addr_rd];
   end

   // rd_valid is the only state: idle -> valid on rd_en, valid -> idle otherwise.
   always_comb begin
      w_valid_nxt = bus.rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_valid_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_out <= '0;
      end else if (bus.rd_en) begin
         r_d_out <= w_rd_data;
      end
   end

   assign bus.d_out    = r_d_out;
   assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_hack_ram8.sv
// tb/tb_hack_ram8.sv - randomized scoreboard bench for hack_ram8
module tb_hack_ram8;
   import hack_pkg::*;

   typedef struct {
      logic       v;
      hack_word_t d;
      string      name;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   exp_t exp_q[$];

   hack_word_t model_mem [RAM8_DEPTH];
   hack_word_t model_dout;

   hack_ram8_if #(.WIDTH(WORD_W), .ADDR_W(RAM8_ADDR_W)) bus ();

   hack_ram8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, ".rd_valid"}, {31'd0, bus.rd_valid}, {31'd0, e.v});
         check({e.name, ".d_out"}, {16'd0, bus.d_out}, {16'd0, e.d});
      end
   end

   task automatic cycle(input string name, input logic ld, input int aw, input hack_word_t din,
                        input logic rd, input int ar);
      exp_t e;
      @(negedge clk);
      bus.load    = ld;
      bus.addr_wr = aw[RAM8_ADDR_W-1:0];
      bus.d_in    = din;
      bus.rd_en   = rd;
      bus.addr_rd = ar[RAM8_ADDR_W-1:0];
      @(posedge clk);
      if (rd) model_dout = (ld && aw == ar) ? din : model_mem[ar];
      if (ld) model_mem[aw] = din;
      e.v    = rd;
      e.d    = model_dout;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic async_reset(input string name);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check({name, ".rd_valid_async"}, {31'd0, bus.rd_valid}, 32'd0);
      check({name, ".d_out_async"}, {16'd0, bus.d_out}, 32'd0);
      foreach (model_mem[i]) model_mem[i] = '0;
      model_dout = '0;
      @(posedge clk);
      @(negedge clk);
      bus.load  = 1'b0;
      bus.rd_en = 1'b0;
      rst_n     = 1'b1;
   endtask

   task automatic idle(input string name, input int n);
      for (int k = 0; k < n; k++) cycle(name, 1'b0, 0, hack_word_t'($urandom), 1'b0, 0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      model_dout = '0;
      foreach (model_mem[i]) model_mem[i] = '0;
      bus.load = 1'b0; bus.addr_wr = '0; bus.d_in = '0;
      bus.rd_en = 1'b0; bus.addr_rd = '0;
      rst_n = 1'b0;
      #3;
      check("reset.rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      check("reset.d_out", {16'd0, bus.d_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) cycle("prefill", 1'b1, i, hack_word_t'(16'h9000 + i), 1'b0, 0);
      cycle("prefill_rd", 1'b0, 0, '0, 1'b1, 3);
      async_reset("reset_mid");
      for (int i = 0; i < 8; i++) cycle("post_reset_rd", 1'b0, 0, '0, 1'b1, i);

      for (int i = 0; i < 8; i++) cycle("wr_all", 1'b1, i, hack_word_t'(16'h1000 + i), 1'b0, 0);
      for (int i = 0; i < 8; i++) cycle("rd_all", 1'b0, 0, '0, 1'b1, i);
      idle("rd_all_end", 1);

      cycle("coll_pre", 1'b1, 5, 16'hAAAA, 1'b0, 0);
      cycle("collision", 1'b1, 5, 16'h5555, 1'b1, 5);
      cycle("coll_reread", 1'b0, 0, '0, 1'b1, 5);

      cycle("indep_pre", 1'b1, 2, 16'h0002, 1'b0, 0);
      cycle("indep", 1'b1, 3, 16'hBEEF, 1'b1, 2);
      cycle("indep_rd3", 1'b0, 0, '0, 1'b1, 3);

      cycle("hold_pre", 1'b1, 6, 16'h1234, 1'b0, 0);
      cycle("hold_rd", 1'b0, 0, '0, 1'b1, 6);
      idle("hold", 3);
      for (int i = 0; i < 8; i++) cycle("hold_verify", 1'b0, 0, '0, 1'b1, i);

      cycle("stream_pre", 1'b1, 7, 16'hFFFF, 1'b0, 0);
      for (int i = 0; i < 4; i++) cycle("stream", 1'b0, 0, '0, 1'b1, 7);
      async_reset("reset_stream");
      cycle("stream_after", 1'b0, 0, '0, 1'b1, 7);
      idle("stream_end", 1);

      for (int i = 0; i < 400; i++) begin
         cycle("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               hack_word_t'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      end
      for (int i = 0; i < 8; i++) cycle("final_rd", 1'b0, 0, '0, 1'b1, i);
      idle("drain", 2);

      @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
